// File: rtl/id_issue_ctrl.sv
// id_issue_ctrl
//   Decode-side issue control for the ID/EX boundary. Passes the decoded
//   control bundle through to the ID/EX register inputs, or substitutes an
//   all-zero bubble on a hazard, a taken-branch flush, or an empty ID slot.
//   Keeps EX/MEM shadows of the last two issue slots for hazard detection
//   and a saturating count of hazard/flush bubbles.
//
// Parameters
//   BRANCH_PENALTY  bubble cycles after a taken branch (1..3)
//   MEM_FWD         1: MEM->EX forwarding exists; 0: also interlock on writes
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   instr_valid           ID holds a real instruction
//   *_d, alu_control_d    decoded control bundle
//   rd_d, rn_d, rm_d      destination / source register numbers
//   uses_rn/rm/flags      operand and condition-flag usage
//   branch_taken_ex       pulse from EX: branch resolved taken
//   *_o, alu_control_o    bundle to ID/EX inputs (bubble = all zero)
//   stall_fetch           hold PC and IF/ID
//   flush_if_id           invalidate IF/ID
//   bubble_count          saturating count of hazard/flush bubbles
module id_issue_ctrl #(
    parameter int unsigned BRANCH_PENALTY = 2,
    parameter bit          MEM_FWD        = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic        reg_write_enable_d,
    input  logic        mem_write_enable_d,
    input  logic        mem_read_enable_d,
    input  logic        mem_to_reg_select_d,
    input  logic        alu_src_select_d,
    input  logic        status_bit_d,
    input  logic        mem_size_d,
    input  logic [3:0]  alu_control_d,
    input  logic [3:0]  rd_d,
    input  logic [3:0]  rn_d,
    input  logic [3:0]  rm_d,
    input  logic        uses_rn,
    input  logic        uses_rm,
    input  logic        uses_flags,
    input  logic        branch_taken_ex,
    output logic        reg_write_enable_o,
    output logic        mem_write_enable_o,
    output logic        mem_read_enable_o,
    output logic        mem_to_reg_select_o,
    output logic        alu_src_select_o,
    output logic        status_bit_o,
    output logic        mem_size_o,
    output logic [3:0]  alu_control_o,
    output logic        stall_fetch,
    output logic        flush_if_id,
    output logic [15:0] bubble_count
);

    typedef enum logic {ISSUE, FLUSH} state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;

    logic        ex_valid_q, ex_load_q, ex_wr_q, ex_setflags_q;
    logic [3:0]  ex_rd_q;
    logic        mem_valid_q, mem_wr_q;
    logic [3:0]  mem_rd_q;

    logic        src_match_ex, src_match_mem;
    logic        load_use, wr_hazard, flag_hazard, hazard;
    logic        issue, count_bubble;

    always_comb begin
        src_match_ex  = (uses_rn && (rn_d == ex_rd_q))  || (uses_rm && (rm_d == ex_rd_q));
        src_match_mem = (uses_rn && (rn_d == mem_rd_q)) || (uses_rm && (rm_d == mem_rd_q));
        load_use      = instr_valid && ex_valid_q && ex_load_q && src_match_ex;
        wr_hazard     = !MEM_FWD && instr_valid &&
                        ((ex_valid_q && ex_wr_q && src_match_ex) ||
                         (mem_valid_q && mem_wr_q && src_match_mem));
        flag_hazard   = instr_valid && uses_flags && ex_valid_q && ex_setflags_q;
        hazard        = load_use || wr_hazard || flag_hazard;
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        issue        = 1'b0;
        stall_fetch  = 1'b0;
        flush_if_id  = 1'b0;
        count_bubble = 1'b0;
        if (reset) begin
            state_d = ISSUE;
            cnt_d   = '0;
        end else if (branch_taken_ex) begin
            // The branch cycle itself is the first of BRANCH_PENALTY bubbles.
            flush_if_id  = 1'b1;
            count_bubble = 1'b1;
            if (BRANCH_PENALTY > 1) begin
                state_d = FLUSH;
                cnt_d   = 2'(BRANCH_PENALTY - 1);
            end else begin
                state_d = ISSUE;
                cnt_d   = '0;
            end
        end else if (state_q == FLUSH) begin
            flush_if_id  = 1'b1;
            count_bubble = 1'b1;
            cnt_d        = cnt_q - 2'd1;
            if (cnt_q <= 2'd1) begin
                state_d = ISSUE;
                cnt_d   = '0;
            end
        end else if (hazard) begin
            stall_fetch  = 1'b1;
            count_bubble = 1'b1;
        end else begin
            issue = instr_valid;
        end
    end

    assign reg_write_enable_o  = issue ? reg_write_enable_d  : 1'b0;
    assign mem_write_enable_o  = issue ? mem_write_enable_d  : 1'b0;
    assign mem_read_enable_o   = issue ? mem_read_enable_d   : 1'b0;
    assign mem_to_reg_select_o = issue ? mem_to_reg_select_d : 1'b0;
    assign alu_src_select_o    = issue ? alu_src_select_d    : 1'b0;
    assign status_bit_o        = issue ? status_bit_d        : 1'b0;
    assign mem_size_o          = issue ? mem_size_d          : 1'b0;
    assign alu_control_o       = issue ? alu_control_d       : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ISSUE;
            cnt_q         <= '0;
            ex_valid_q    <= 1'b0;
            ex_rd_q       <= '0;
            ex_load_q     <= 1'b0;
            ex_wr_q       <= 1'b0;
            ex_setflags_q <= 1'b0;
            mem_valid_q   <= 1'b0;
            mem_rd_q      <= '0;
            mem_wr_q      <= 1'b0;
            bubble_count  <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            mem_valid_q   <= ex_valid_q;
            mem_rd_q      <= ex_rd_q;
            mem_wr_q      <= ex_wr_q;
            ex_valid_q    <= issue;
            ex_rd_q       <= rd_d;
            ex_load_q     <= mem_read_enable_d;
            ex_wr_q       <= reg_write_enable_d;
            ex_setflags_q <= status_bit_d;
            if (count_bubble && (bubble_count != '1))
                bubble_count <= bubble_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_id_issue_ctrl.sv
// Directed bench for id_issue_ctrl. dut1: BRANCH_PENALTY=2, MEM_FWD=1
// (vector table + saturation); dut2: BRANCH_PENALTY=3, MEM_FWD=0
// (reset mid-flush, write interlock, 3-cycle flush). Both share inputs.
module tb_id_issue_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, instr_valid, branch_taken_ex;
    logic [6:0]  ctl;
    logic [3:0]  alu_control_d, rd_d, rn_d, rm_d;
    logic [2:0]  uses;

    logic [6:0]  ctl1, ctl2;
    logic [3:0]  alu1, alu2;
    logic        stall1, stall2, flush1, flush2;
    logic [15:0] cnt1, cnt2;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    id_issue_ctrl #(.BRANCH_PENALTY(2), .MEM_FWD(1'b1)) dut1 (
        .clk(clk), .reset(reset), .instr_valid(instr_valid),
        .reg_write_enable_d(ctl[6]), .mem_write_enable_d(ctl[5]),
        .mem_read_enable_d(ctl[4]), .mem_to_reg_select_d(ctl[3]),
        .alu_src_select_d(ctl[2]), .status_bit_d(ctl[1]), .mem_size_d(ctl[0]),
        .alu_control_d(alu_control_d), .rd_d(rd_d), .rn_d(rn_d), .rm_d(rm_d),
        .uses_rn(uses[2]), .uses_rm(uses[1]), .uses_flags(uses[0]),
        .branch_taken_ex(branch_taken_ex),
        .reg_write_enable_o(ctl1[6]), .mem_write_enable_o(ctl1[5]),
        .mem_read_enable_o(ctl1[4]), .mem_to_reg_select_o(ctl1[3]),
        .alu_src_select_o(ctl1[2]), .status_bit_o(ctl1[1]), .mem_size_o(ctl1[0]),
        .alu_control_o(alu1), .stall_fetch(stall1), .flush_if_id(flush1),
        .bubble_count(cnt1)
    );

    id_issue_ctrl #(.BRANCH_PENALTY(3), .MEM_FWD(1'b0)) dut2 (
        .clk(clk), .reset(reset), .instr_valid(instr_valid),
        .reg_write_enable_d(ctl[6]), .mem_write_enable_d(ctl[5]),
        .mem_read_enable_d(ctl[4]), .mem_to_reg_select_d(ctl[3]),
        .alu_src_select_d(ctl[2]), .status_bit_d(ctl[1]), .mem_size_d(ctl[0]),
        .alu_control_d(alu_control_d), .rd_d(rd_d), .rn_d(rn_d), .rm_d(rm_d),
        .uses_rn(uses[2]), .uses_rm(uses[1]), .uses_flags(uses[0]),
        .branch_taken_ex(branch_taken_ex),
        .reg_write_enable_o(ctl2[6]), .mem_write_enable_o(ctl2[5]),
        .mem_read_enable_o(ctl2[4]), .mem_to_reg_select_o(ctl2[3]),
        .alu_src_select_o(ctl2[2]), .status_bit_o(ctl2[1]), .mem_size_o(ctl2[0]),
        .alu_control_o(alu2), .stall_fetch(stall2), .flush_if_id(flush2),
        .bubble_count(cnt2)
    );

    // ctl bits: {reg_write, mem_write, mem_read, mem_to_reg, alu_src, status, mem_size}
    localparam logic [6:0] C_ADD = 7'b1000000;
    localparam logic [6:0] C_LDR = 7'b1011100;
    localparam logic [6:0] C_CMP = 7'b0000010;
    // uses bits: {uses_rn, uses_rm, uses_flags}

    typedef struct {
        logic        iv;
        logic [6:0]  ctl;
        logic [3:0]  alu, rd, rn, rm;
        logic [2:0]  uses;
        logic        br;
        logic        exp_bub, exp_stall, exp_flush;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[29];

    function automatic vec_t mk(logic iv, logic [6:0] c, logic [3:0] alu, logic [3:0] rd,
                                logic [3:0] rn, logic [3:0] rm, logic [2:0] u, logic br,
                                logic bub, logic st, logic fl, logic [15:0] cnt);
        vec_t v;
        v.iv = iv; v.ctl = c; v.alu = alu; v.rd = rd; v.rn = rn; v.rm = rm;
        v.uses = u; v.br = br; v.exp_bub = bub; v.exp_stall = st; v.exp_flush = fl;
        v.exp_cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [6:0] c, input logic [3:0] alu,
                         input logic [3:0] rd, input logic [3:0] rn, input logic [3:0] rm,
                         input logic [2:0] u, input logic br);
        instr_valid = iv; ctl = c; alu_control_d = alu; rd_d = rd; rn_d = rn;
        rm_d = rm; uses = u; branch_taken_ex = br;
    endtask

    // advance one clock; leave the bench 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, '0, '0, '0, '0, '0, '0, 1'b0);

        vecs[0]  = mk(0, C_ADD, 4'h2, 1, 3, 4, 3'b110, 0,  1, 0, 0, 0);
        vecs[1]  = mk(1, C_ADD, 4'h2, 1, 3, 4, 3'b110, 0,  0, 0, 0, 0);
        vecs[2]  = mk(1, C_LDR, 4'h0, 2, 1, 0, 3'b100, 0,  0, 0, 0, 0);
        vecs[3]  = mk(1, C_ADD, 4'h2, 3, 2, 0, 3'b100, 0,  1, 1, 0, 0);
        vecs[4]  = mk(1, C_ADD, 4'h2, 3, 2, 0, 3'b100, 0,  0, 0, 0, 1);
        vecs[5]  = mk(1, C_CMP, 4'hA, 0, 3, 1, 3'b110, 0,  0, 0, 0, 1);
        vecs[6]  = mk(1, C_ADD, 4'hD, 5, 0, 3, 3'b011, 0,  1, 1, 0, 1);
        vecs[7]  = mk(1, C_ADD, 4'hD, 5, 0, 3, 3'b011, 0,  0, 0, 0, 2);
        vecs[8]  = mk(1, C_CMP, 4'hA, 0, 3, 1, 3'b110, 0,  0, 0, 0, 2);
        vecs[9]  = mk(1, C_ADD, 4'h4, 6, 5, 6, 3'b110, 0,  0, 0, 0, 2);
        vecs[10] = mk(1, C_ADD, 4'h2, 7, 1, 1, 3'b110, 1,  1, 0, 1, 2);
        vecs[11] = mk(1, C_ADD, 4'h2, 7, 1, 1, 3'b110, 0,  1, 0, 1, 3);
        vecs[12] = mk(1, C_ADD, 4'h2, 7, 1, 1, 3'b110, 0,  0, 0, 0, 4);
        vecs[13] = mk(1, C_LDR, 4'h0, 8, 1, 0, 3'b100, 0,  0, 0, 0, 4);
        vecs[14] = mk(1, C_ADD, 4'h2, 9, 8, 0, 3'b100, 1,  1, 0, 1, 4);
        vecs[15] = mk(1, C_ADD, 4'h2, 9, 8, 0, 3'b100, 0,  1, 0, 1, 5);
        vecs[16] = mk(1, C_ADD, 4'h2, 9, 8, 0, 3'b100, 0,  0, 0, 0, 6);
        vecs[17] = mk(1, C_ADD, 4'h2, 1, 3, 4, 3'b110, 1,  1, 0, 1, 6);
        vecs[18] = mk(1, C_ADD, 4'h2, 1, 3, 4, 3'b110, 1,  1, 0, 1, 7);
        vecs[19] = mk(1, C_ADD, 4'h2, 1, 3, 4, 3'b110, 0,  1, 0, 1, 8);
        vecs[20] = mk(1, C_ADD, 4'h2, 1, 3, 4, 3'b110, 0,  0, 0, 0, 9);
        vecs[21] = mk(1, C_LDR, 4'h0, 15, 1, 0, 3'b100, 0, 0, 0, 0, 9);
        vecs[22] = mk(1, C_ADD, 4'h2, 3, 0, 15, 3'b010, 0, 1, 1, 0, 9);
        vecs[23] = mk(1, C_ADD, 4'h2, 3, 0, 15, 3'b010, 0, 0, 0, 0, 10);
        vecs[24] = mk(1, C_LDR, 4'h0, 4, 1, 0, 3'b100, 0,  0, 0, 0, 10);
        vecs[25] = mk(1, C_ADD, 4'h2, 3, 4, 5, 3'b010, 0,  0, 0, 0, 10);
        vecs[26] = mk(1, C_LDR, 4'h0, 9, 1, 0, 3'b100, 0,  0, 0, 0, 10);
        vecs[27] = mk(0, C_ADD, 4'h2, 3, 9, 0, 3'b100, 0,  1, 0, 0, 10);
        vecs[28] = mk(1, C_ADD, 4'h2, 3, 9, 0, 3'b100, 0,  0, 0, 0, 10);

        repeat (2) tick();
        reset = 1'b0;
        chk("reset_count", cnt1, 16'd0);

        // ---- table: dut1 (penalty 2, forwarding) ----
        for (int i = 0; i < 29; i++) begin
            drive(vecs[i].iv, vecs[i].ctl, vecs[i].alu, vecs[i].rd, vecs[i].rn,
                  vecs[i].rm, vecs[i].uses, vecs[i].br);
            #3;
            chk($sformatf("v%0d_bundle", i), {5'b0, ctl1, alu1},
                vecs[i].exp_bub ? 16'd0 : {5'b0, vecs[i].ctl, vecs[i].alu});
            chk($sformatf("v%0d_stall", i), {15'b0, stall1}, {15'b0, vecs[i].exp_stall});
            chk($sformatf("v%0d_flush", i), {15'b0, flush1}, {15'b0, vecs[i].exp_flush});
            chk($sformatf("v%0d_count", i), cnt1, vecs[i].exp_cnt);
            tick();
        end

        // ---- dut2: reset in the 2nd cycle of a 3-cycle flush ----
        reset = 1'b1;
        drive(1'b0, '0, '0, '0, '0, '0, '0, 1'b0);
        tick();
        reset = 1'b0;
        drive(1'b1, C_ADD, 4'h2, 1, 3, 4, 3'b110, 1'b1);
        #3;
        chk("p3_br_flush", {15'b0, flush2}, 16'd1);
        tick();
        branch_taken_ex = 1'b0;
        reset = 1'b1;
        #3;
        chk("p3_flush2", {15'b0, flush2}, 16'd0);
        tick();
        reset = 1'b0;
        #3;
        chk("rst_issue_bundle", {5'b0, ctl2, alu2}, {5'b0, C_ADD, 4'h2});
        chk("rst_issue_flush", {15'b0, flush2}, 16'd0);
        chk("rst_issue_stall", {15'b0, stall2}, 16'd0);
        chk("rst_issue_count", cnt2, 16'd0);
        tick();
        #3;
        chk("rst_issue2_flush", {15'b0, flush2}, 16'd0);
        chk("rst_issue2_bundle", {5'b0, ctl2, alu2}, {5'b0, C_ADD, 4'h2});
        tick();

        // ---- dut2: no forwarding, write in EX then MEM -> 2 bubbles ----
        drive(1'b1, C_ADD, 4'h2, 2, 1, 0, 3'b100, 1'b0);
        #3;
        chk("nofwd_ex_bub", {5'b0, ctl2, alu2}, 16'd0);
        chk("nofwd_ex_stall", {15'b0, stall2}, 16'd1);
        tick();
        #3;
        chk("nofwd_mem_bub", {5'b0, ctl2, alu2}, 16'd0);
        chk("nofwd_mem_stall", {15'b0, stall2}, 16'd1);
        tick();
        #3;
        chk("nofwd_issue", {5'b0, ctl2, alu2}, {5'b0, C_ADD, 4'h2});
        chk("nofwd_issue_stall", {15'b0, stall2}, 16'd0);
        chk("nofwd_count", cnt2, 16'd2);
        tick();

        // ---- dut2: penalty 3 -> three flush cycles ----
        drive(1'b1, C_ADD, 4'h2, 5, 3, 4, 3'b110, 1'b1);
        for (int k = 0; k < 3; k++) begin
            #3;
            chk($sformatf("p3_flush_c%0d", k), {15'b0, flush2}, 16'd1);
            chk($sformatf("p3_bub_c%0d", k), {5'b0, ctl2, alu2}, 16'd0);
            tick();
            branch_taken_ex = 1'b0;
        end
        #3;
        chk("p3_after_flush", {15'b0, flush2}, 16'd0);
        chk("p3_after_bundle", {5'b0, ctl2, alu2}, {5'b0, C_ADD, 4'h2});
        chk("p3_count", cnt2, 16'd5);
        tick();

        // ---- dut1: bubble counter saturation ----
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(1'b1, C_ADD, 4'h2, 1, 3, 4, 3'b110, 1'b1);
        repeat (65534) @(posedge clk);
        #1;
        chk("sat_fffe", cnt1, 16'hFFFE);
        tick();
        chk("sat_ffff", cnt1, 16'hFFFF);
        repeat (5) tick();
        chk("sat_hold", cnt1, 16'hFFFF);
        branch_taken_ex = 1'b0;
        tick();
        chk("sat_hold2", cnt1, 16'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_issue_ctrl.md
# id_issue_ctrl

Issue controller at the decode end of the ID/EX boundary. It takes the raw control bundle from the decoder and drives the ID/EX register inputs with either that bundle or an all-zero bubble. It tracks the last two issued instructions (EX and MEM shadows) to detect load-use and flag hazards, stalls fetch/decode, and runs a flush sequence after a taken branch. It also keeps a saturating bubble counter for performance monitoring.

## Interface
- BRANCH_PENALTY, 2, number of bubble cycles inserted after a taken branch (1..3)
- MEM_FWD, 1, 1 = MEM→EX forwarding exists; 0 = also interlock on any register write in EX or MEM
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; clock clk
- instr_valid  in  1  ID holds a real instruction
- reg_write_enable_d, mem_write_enable_d, mem_read_enable_d, mem_to_reg_select_d, alu_src_select_d, status_bit_d, mem_size_d  in  1 each  decoded control bundle
- alu_control_d  in  4  decoded ALU op
- rd_d, rn_d, rm_d  in  4 each  destination and source register numbers
- uses_rn, uses_rm, uses_flags  in  1 each  operand/condition-flag usage
- branch_taken_ex  in  1  single-cycle pulse from EX: branch resolved taken
- reg_write_enable_o … mem_size_o, alu_control_o  out  same widths  bundle to ID/EX inputs
- stall_fetch  out  1  hold PC and IF/ID this cycle
- flush_if_id  out  1  invalidate IF/ID this cycle
- bubble_count  out  16  saturating count of bubbles issued

## Operation
- FSM states: ISSUE, FLUSH.
- Hazard (evaluated in ISSUE, combinational on current inputs and shadows):
  - load-use: instr_valid & ex_valid & ex_load & ((uses_rn & rn_d==ex_rd) | (uses_rm & rm_d==ex_rd))
  - MEM_FWD=0 adds: register match against any ex_wr or mem_wr shadow
  - flags: instr_valid & uses_flags & ex_valid & ex_setflags
- Issue decision per cycle, priority high→low: reset, branch_taken_ex, FLUSH state, hazard, normal issue.
  - branch_taken_ex (any state): bubble, flush_if_id=1, stall_fetch=0, enter FLUSH with counter = BRANCH_PENALTY−1; if BRANCH_PENALTY=1, stay in ISSUE.
  - FLUSH: bubble, flush_if_id=1; counter decrements; return to ISSUE when counter is 0 at the edge.
  - hazard: bubble, stall_fetch=1.
  - normal: outputs = decoded bundle, gated to bubble when instr_valid=0.
- Bubble = every control output 0, alu_control_o=4'b0000.
- Shadow update each edge: MEM ← EX; EX ← {valid=issued non-bubble, rd_d, load=mem_read_enable_d, wr=reg_write_enable_d, setflags=status_bit_d}. A bubble writes EX valid=0.
- bubble_count increments on each bubble cycle caused by hazard or flush (not instr_valid=0). It saturates at 16'hFFFF.

## Timing
- Reset (synchronous): state=ISSUE, counter=0, both shadows invalid, bubble_count=0.
- Control outputs, stall_fetch and flush_if_id are combinational. With shadows invalid after reset, they are: bubble, stall_fetch=0, flush_if_id=0 when instr_valid=0.
- Load-use with MEM_FWD=1: exactly 1 bubble. The next cycle the load is in MEM, so the hazard clears and the held instruction issues.
- MEM_FWD=0 register hazard: up to 2 bubbles.
- Flags hazard: exactly 1 bubble.
- Taken branch: BRANCH_PENALTY consecutive bubble cycles starting in the cycle branch_taken_ex=1.
- branch_taken_ex coinciding with a hazard: flush wins and stall_fetch=0.
- branch_taken_ex during FLUSH: restarts the counter.
- Reset mid-FLUSH or mid-stall: next cycle is ISSUE with clean shadows, and no residual bubbles are issued.
- Register number 15 (PC) is compared like any other register.

## Test plan
- Reset, then instr_valid=1, ADD (reg_write=1, alu_control=4'b0010, rd=1) → outputs equal decoded bundle in the same cycle; stall_fetch=0; bubble_count=0.
- LDR r2 issued, next instruction ADD using rn=2 (MEM_FWD=1) → one cycle with bubble and stall_fetch=1; ADD issues the following cycle; bubble_count=1.
- CMP (status_bit=1), then conditional MOV with uses_flags=1 → 1 bubble, then MOV issues; a non-flag-using instruction after CMP issues without a stall.
- branch_taken_ex pulse with BRANCH_PENALTY=2 → 2 consecutive cycles of bubble and flush_if_id=1, then normal issue; bubble_count increases by 2. Repeat while a load-use hazard is pending → flush_if_id=1, stall_fetch=0.
- reset asserted in the 2nd cycle of a BRANCH_PENALTY=3 flush → after reset, the first valid instruction issues immediately; flush_if_id=0; bubble_count=0.
- Force 65,540 hazard bubbles → bubble_count holds at 16'hFFFF.
